// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register file's single write port.
// Optional read-port bypass of the in-flight write: define REGWB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] req_regn,
  input  logic [32*NREQ-1:0] req_data,
  input  logic              hold,
  output logic [NREQ-1:0]   gnt,
  output logic [4:0]        wregn,
  output logic [31:0]       wdata,
  output logic              wen,
  output logic [7:0]        drop_cnt
`ifdef REGWB_BYPASS_EN
  ,
  input  logic [4:0]        rd1n,
  input  logic [4:0]        rd2n,
  input  logic [31:0]       rd1i,
  input  logic [31:0]       rd2i,
  output logic [31:0]       rd1o,
  output logic [31:0]       rd2o
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [PW:0]       idx_sum;
  logic              grant;
  logic [4:0]        sel_regn;
  logic [31:0]       sel_data;

  // Rotate requests so bit 0 is the current priority holder; scan downward so
  // the lowest rotated offset is the one that sticks.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NREQ-1:0];
    win_vld = 1'b0;
    win_idx = '0;
    idx_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_vld = 1'b1;
        idx_sum = {1'b0, ptr} + (PW+1)'(k);
        if (idx_sum >= (PW+1)'(NREQ)) idx_sum = idx_sum - (PW+1)'(NREQ);
        win_idx = idx_sum[PW-1:0];
      end
    end
  end

  assign grant = win_vld & ~hold & reset;

  always_comb begin
    gnt      = '0;
    sel_regn = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == PW'(k)) begin
        gnt[k]   = grant;
        sel_regn = req_regn[5*k +: 5];
        sel_data = req_data[32*k +: 32];
      end
    end
  end

  always_comb begin
    if (win_idx == PW'(NREQ - 1)) ptr_nxt = '0;
    else                          ptr_nxt = win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      wregn    <= '0;
      wdata    <= '0;
      wen      <= 1'b0;
      drop_cnt <= '0;
    end else if (grant) begin
      ptr   <= ptr_nxt;
      wregn <= sel_regn;
      wdata <= sel_data;
      wen   <= |sel_regn;
      // Writes to r0 are swallowed but counted.
      if (sel_regn == 5'd0 && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else begin
      wen <= 1'b0;
    end
  end

`ifdef REGWB_BYPASS_EN
  always_comb begin
    rd1o = (wen && rd1n == wregn && rd1n != 5'd0) ? wdata : rd1i;
    rd2o = (wen && rd2n == wregn && rd2n != 5'd0) ? wdata : rd2i;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] req_regn;
  logic [32*NREQ-1:0] req_data;
  logic              hold;
  logic [NREQ-1:0]   gnt;
  logic [4:0]        wregn;
  logic [31:0]       wdata;
  logic              wen;
  logic [7:0]        drop_cnt;
`ifdef REGWB_BYPASS_EN
  logic [4:0]        rd1n, rd2n;
  logic [31:0]       rd1i, rd2i, rd1o, rd2o;
`endif

  logic [4:0]  regn [NREQ];
  logic [31:0] data [NREQ];

  int n_checks = 0;
  int n_fails  = 0;

  int          mptr;
  logic        m_wen;
  logic [4:0]  m_wregn;
  logic [31:0] m_wdata;
  int          m_drop;

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_regn (req_regn),
    .req_data (req_data),
    .hold     (hold),
    .gnt      (gnt),
    .wregn    (wregn),
    .wdata    (wdata),
    .wen      (wen),
    .drop_cnt (drop_cnt)
`ifdef REGWB_BYPASS_EN
    ,
    .rd1n     (rd1n),
    .rd2n     (rd2n),
    .rd1i     (rd1i),
    .rd2i     (rd2i),
    .rd1o     (rd1o),
    .rd2o     (rd2o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_regn = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_regn[5*i +: 5]  = regn[i];
      req_data[32*i +: 32] = data[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr    = 0;
    m_wen   = 1'b0;
    m_wregn = '0;
    m_wdata = '0;
    m_drop  = 0;
  endtask

  // Round-robin rule: first requester found searching from mptr upward, modulo NREQ.
  function automatic int model_winner();
    if (hold) return -1;
    for (int off = 0; off < NREQ; off++)
      if (req[(mptr + off) % NREQ]) return (mptr + off) % NREQ;
    return -1;
  endfunction

  // Entered at a falling edge with inputs already set; leaves at the next falling edge.
  task automatic cycle(output int w);
    logic [NREQ-1:0] exp_gnt;
    w = model_winner();
    exp_gnt = (w >= 0) ? NREQ'(1 << w) : '0;
    #1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    @(posedge clk);
    if (w >= 0) begin
      mptr    = (w + 1) % NREQ;
      m_wregn = regn[w];
      m_wdata = data[w];
      m_wen   = (regn[w] != 5'd0);
      if (regn[w] == 5'd0 && m_drop < 255) m_drop++;
    end else begin
      m_wen = 1'b0;
    end
    #1;
    check("wen", 32'(wen), 32'(m_wen));
    check("wregn", 32'(wregn), 32'(m_wregn));
    check("wdata", wdata, m_wdata);
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    @(negedge clk);
  endtask

  initial begin
    int w;
    int cont_prev;
    reset = 1'b0;
    hold  = 1'b0;
    req   = '1;
    for (int i = 0; i < NREQ; i++) begin
      regn[i] = 5'(i + 1);
      data[i] = 32'h1000 + 32'(i);
    end
`ifdef REGWB_BYPASS_EN
    rd1n = '0; rd2n = '0; rd1i = '0; rd2i = '0;
`endif
    model_reset();
    #2;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_wregn", 32'(wregn), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // single requester
    req = 3'b010; regn[1] = 5'd5; data[1] = 32'hDEADBEEF;
    cycle(w);
    check("single_winner", 32'(w), 32'd1);
    req = '0;
    cycle(w);

    // contention, all requesters continuously
    req = '1;
    regn[0] = 5'd1; regn[1] = 5'd2; regn[2] = 5'd3;
    cont_prev = -1;
    for (int c = 0; c < 6; c++) begin
      cycle(w);
      check("cont_no_repeat", 32'(w != cont_prev), 32'd1);
      cont_prev = w;
    end
    req = '0;
    cycle(w);

    // writes to r0 via requester 2
    req = 3'b100; regn[2] = 5'd0; data[2] = 32'hCAFE0000;
    for (int c = 0; c < 3; c++) cycle(w);
    check("drop3", 32'(drop_cnt), 32'd3);
    for (int c = 0; c < 300; c++) cycle(w);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    req = '0;
    cycle(w);

    // hold while requester 0 waits, after one write is latched
    req = 3'b001; regn[0] = 5'd4; data[0] = 32'h44444444;
    cycle(w);
    hold = 1'b1;
    for (int c = 0; c < 4; c++) cycle(w);
    hold = 1'b0;
    cycle(w);
    check("hold_release_winner", 32'(w), 32'd0);

    // reset asserted mid-write
    regn[0] = 5'd9; data[0] = 32'h99999999;
    cycle(w);
    check("pre_reset_wen", 32'(wen), 32'd1);
    reset = 1'b0;
    #1;
    check("async_wen", 32'(wen), 32'd0);
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_drop", 32'(drop_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    req = 3'b110; regn[1] = 5'd11; regn[2] = 5'd12;
    cycle(w);
    check("post_reset_winner", 32'(w), 32'd1);
    req = '0;

    // randomized traffic honouring the req/gnt handshake
    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(0, 9) == 0);
      cycle(w);
      if (w >= 0) begin
        if ($urandom_range(0, 1) == 0) req[w] = 1'b0;
        else begin
          regn[w] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          data[w] = $urandom;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && i != w && $urandom_range(0, 2) == 0) begin
          req[i]  = 1'b1;
          regn[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          data[i] = $urandom;
        end
      end
    end
    hold = 1'b0;
    req  = '0;
    cycle(w);

`ifdef REGWB_BYPASS_EN
    req = 3'b001; regn[0] = 5'd7; data[0] = 32'h00001234;
    cycle(w);
    req = '0;
    rd1n = 5'd7; rd2n = 5'd8; rd1i = $urandom; rd2i = $urandom;
    #1;
    check("byp_rd1o", rd1o, 32'h00001234);
    check("byp_rd2o", rd2o, rd2i);
    cycle(w);
    req = 3'b001; regn[0] = 5'd0; data[0] = 32'h55555555;
    cycle(w);
    req = '0;
    rd1n = 5'd0; rd2n = 5'd0; rd1i = $urandom; rd2i = $urandom;
    #1;
    check("byp_r0_rd1o", rd1o, rd1i);
    check("byp_r0_rd2o", rd2o, rd2i);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file's single write port. Shares that port among NREQ writeback requesters (ALU, load unit, multi-cycle mul/div) using round-robin arbitration and a one-entry registered output stage. Drives the register file's wregn/wdata/wen directly. Optionally provides read-port bypass so that a write in flight is visible to same-cycle reads.

## Interface
- NREQ, 3, number of requesters; legal range 2..8
- clk  in  1  write-port clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- req  in  NREQ  per-requester write request (valid)
- req_regn  in  5*NREQ  destination register; requester i uses bits [5i+4:5i]
- req_data  in  32*NREQ  write data; requester i uses bits [32i+31:32i]
- hold  in  1  pipeline freeze; blocks new grants
- gnt  out  NREQ  one-hot, combinational acceptance (ready)
- wregn  out  5  to register file write index
- wdata  out  32  to register file write data
- wen  out  1  to register file write enable
- drop_cnt  out  8  saturating count of accepted writes to register 0
- rd1n, rd2n  in  5 each  register-file read indices (REGWB_BYPASS_EN only)
- rd1i, rd2i  in  32 each  raw register-file read data (REGWB_BYPASS_EN only)
- rd1o, rd2o  out  32 each  bypassed read data (REGWB_BYPASS_EN only)

## Operation
- State: round-robin pointer ptr (0..NREQ-1), output register {wregn, wdata, wen}, drop_cnt.
- Arbitration, each cycle with hold=0: winner = first i with req[i]=1, searching ptr, ptr+1, … modulo NREQ. gnt[winner]=1; all other gnt bits 0. No req → gnt=0.
- hold=1: gnt=0 regardless of req.
- Handshake: requester keeps req/regn/data stable until it samples gnt=1 at a rising edge, then it either drops req or presents its next write. gnt depends only on req, hold and ptr, never on the data fields.
- On an edge with a grant to i: ptr ← (i+1) mod NREQ. wregn ← regn_i. wdata ← data_i. wen ← (regn_i ≠ 0).
- A grant with regn_i = 0 is accepted but discarded: wen=0 and drop_cnt increments, saturating at 255.
- On an edge with no grant: wen ← 0. wregn, wdata and ptr hold.
- Requester i is granted within NREQ cycles of raising req, given hold=0. There is no starvation.

## Timing
- Reset values: ptr=0, wen=0, wregn=0, wdata=0, drop_cnt=0. gnt=0 while reset=0.
- Latency: grant in cycle k → wen=1 during cycle k+1 → register file updated at the end of cycle k+1. The result is readable raw from cycle k+2.
- Throughput is one write per cycle. Back-to-back grants produce a continuous wen.
- hold rising in cycle k: the write latched at the end of cycle k-1 still completes in cycle k. No new wen appears from cycle k+1 on.
- Reset asserted mid-operation: the in-flight write is lost (wen drops immediately, asynchronously). Requesters must re-present their writes.
- Simultaneous req from all requesters, starting at ptr=0: grant order is 0,1,…,NREQ-1,0,…

## Configuration
- REGWB_BYPASS_EN defined: the rd1/rd2 ports exist.
  - rdXo = wdata when wen=1 and rdXn = wregn and rdXn ≠ 0; otherwise rdXo = rdXi.
  - The bypass is purely combinational.
- REGWB_BYPASS_EN undefined: the rd ports are absent. A consumer reading the destination register in cycle k+1 gets the old value.

## Test plan
- Reset: drive reset=0 mid-write with wen=1 → wen, gnt, drop_cnt and ptr all 0 immediately; first grant after release goes to the lowest requesting index.
- Single requester: req[1]=1, regn=5, data=0xDEADBEEF at cycle k → gnt[1]=1 in k; wen=1, wregn=5, wdata=0xDEADBEEF in k+1; register 5 reads 0xDEADBEEF in k+2.
- Contention: all three req held high with regn=1/2/3 for 6 cycles → grants 0,1,2,0,1,2; wen continuous; no grant twice in a row while others wait.
- Register 0: requester 2 writes regn=0 three times → three gnts, wen=0 throughout, drop_cnt=3; 300 such writes → drop_cnt=255.
- hold: hold=1 for 4 cycles with req[0]=1 → gnt=0 for all 4 cycles, the previously latched write completes once, then wen=0; gnt[0]=1 in the first cycle after hold=0.
- Bypass (REGWB_BYPASS_EN): wen=1, wregn=7, wdata=0x1234; rd1n=7, rd2n=8 → rd1o=0x1234 and rd2o=rd2i. With wregn=0, rdXn=0 → rdXo=rdXi.
